mem_stage_ctrl: RTL and testbench

Memory-stage controller of the pipelined CPU: consumes the EX/MEM segment outputs and runs a request/acknowledge handshake with a variable-latency data memory. It stalls the upstream pipeline while an access is outstanding and drives the MEM/WB segment outputs consumed by writeback. Non-memory instructions pass straight through with one-cycle latency.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_stage_ctrl_if.sv | 42 ++++
 rtl/segment_mem_wb.sv | 73 +++++++
 rtl/mem_stage_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the memory-stage controller and its MEM/WB segment:
//   - state_e        : controller FSM states (IDLE, REQ)
//   - TIMEOUT_DEFAULT: default REQ-cycle limit for the optional watchdog
//   - wb_ctrl_t      : writeback control bundle (PCSrc, RegWrite, MemtoReg)
//   - WB_CTRL_BUBBLE : control bundle value for an inserted bubble
// -----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_CTRL_BUBBLE = '{pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Request/acknowledge bus between the memory-stage controller and the data
// memory.
//   dmem_req   : access request (master -> slave)
//   dmem_we    : write strobe, valid with dmem_req
//   dmem_addr  : access address
//   dmem_wdata : store data
//   dmem_ack   : access complete (slave -> master), dmem_rdata valid same cycle
//   dmem_rdata : load data
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface mem_stage_ctrl_if #(
    parameter int unsigned DATA_W = 32
);

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/segment_mem_wb.sv
// -----------------------------------------------------------------------------
// segment_mem_wb
// MEM/WB segment register, updated on the falling clock edge.
//   clk, rst   : clock (falling edge active), asynchronous active-high reset
//   load       : capture all inputs at the next falling edge
//   bubble     : clear the control bundle, hold the data fields
//   ctrl_in    : writeback control bundle
//   wa3_in     : destination register
//   alu_in     : ALU result / address
//   rd_in      : load data
//   ctrl_out, wa3_out, alu_out, rd_out : registered segment outputs
// bubble takes priority over load; with neither asserted the segment holds.
// -----------------------------------------------------------------------------
module segment_mem_wb
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  wb_ctrl_t          ctrl_in,
    input  logic [REG_AW-1:0] wa3_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] rd_in,
    output wb_ctrl_t          ctrl_out,
    output logic [REG_AW-1:0] wa3_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] rd_out
);

    wb_ctrl_t          ctrl_d, ctrl_q;
    logic [REG_AW-1:0] wa3_d,  wa3_q;
    logic [DATA_W-1:0] alu_d,  alu_q;
    logic [DATA_W-1:0] rd_d,   rd_q;

    always_comb begin
        ctrl_d = ctrl_q;
        wa3_d  = wa3_q;
        alu_d  = alu_q;
        rd_d   = rd_q;
        if (bubble) begin
            ctrl_d = WB_CTRL_BUBBLE;
        end else if (load) begin
            ctrl_d = ctrl_in;
            wa3_d  = wa3_in;
            alu_d  = alu_in;
            rd_d   = rd_in;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= WB_CTRL_BUBBLE;
            wa3_q  <= '0;
            alu_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            wa3_q  <= wa3_d;
            alu_q  <= alu_d;
            rd_q   <= rd_d;
        end
    end

    assign ctrl_out = ctrl_q;
    assign wa3_out  = wa3_q;
    assign alu_out  = alu_q;
    assign rd_out   = rd_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller: takes the EX/MEM segment outputs, runs a
// request/acknowledge access to a variable-latency data memory, stalls the
// upstream pipeline while an access is outstanding and drives the MEM/WB
// segment. Non-memory instructions pass through with one-cycle latency.
//
// Ports:
//   clk, rst          : clock (state updates on falling edge), async reset
//   PCSrcM, RegWriteM, MemtoRegM, MemWriteM : EX/MEM control
//   ALUOutM           : address or ALU result
//   WriteDataM        : store data
//   WA3M              : destination register
//   dmem              : data-memory bus (mem_stage_ctrl_if.master)
//   StallM            : hold IF..EX/MEM segments
//   PCSrcW, RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WA3W : MEM/WB outputs
//   mem_err           : sticky access-timeout flag
//
// Build option:
//   MEM_TIMEOUT_EN : enables the REQ watchdog. After TIMEOUT REQ cycles
//                    without ack the access is abandoned, a bubble is sent to
//                    writeback and mem_err is set until reset. Without it,
//                    REQ waits indefinitely and mem_err is constant 0.
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 4,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    input  logic              MemWriteM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [REG_AW-1:0] WA3M,
    mem_stage_ctrl_if.master  dmem,
    output logic              StallM,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [REG_AW-1:0] WA3W,
    output logic              mem_err
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_stage_ctrl: TIMEOUT must be in 2..255");
    end

    state_e            state_d, state_q;
    logic              mem_op;
    logic              in_req;
    logic              ack;
    logic              tmo_hit;
    logic              stall;
    logic              seg_load;
    logic              seg_bubble;
    logic              rd_sel_mem;
    logic [DATA_W-1:0] rd_in;
    wb_ctrl_t          ctrl_m;
    wb_ctrl_t          ctrl_w;

    assign mem_op = MemtoRegM | MemWriteM;
    assign in_req = (state_q == ST_REQ);
    // An ack is only meaningful while a request is outstanding.
    assign ack    = in_req & dmem.dmem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_d, cnt_q;
    logic       err_d, err_q;

    // cnt_q holds the number of completed REQ cycles; it is zeroed while in
    // IDLE so every REQ entry starts from zero.
    assign tmo_hit = in_req & (cnt_q == TMO_LAST);

    always_comb begin
        cnt_d = (state_q == ST_IDLE) ? '0 : cnt_q + 8'd1;
        err_d = err_q | (tmo_hit & ~ack);
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign mem_err = 1'b0;
`endif

    // ack has priority over the watchdog limit in the same cycle.
    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        seg_load   = 1'b0;
        seg_bubble = 1'b0;
        rd_sel_mem = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    seg_bubble = 1'b1;
                    state_d    = ST_REQ;
                end else begin
                    seg_load   = 1'b1;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    seg_load   = 1'b1;
                    rd_sel_mem = MemtoRegM;
                    state_d    = ST_IDLE;
                end else if (tmo_hit) begin
                    seg_bubble = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stall      = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // StallM is decoded from M inputs in IDLE, so it is forced low while
    // reset is asserted rather than relying on the state register alone.
    assign StallM = stall & ~rst;

    assign dmem.dmem_req   = in_req;
    assign dmem.dmem_we    = in_req & MemWriteM;
    assign dmem.dmem_addr  = in_req ? ALUOutM    : '0;
    assign dmem.dmem_wdata = in_req ? WriteDataM : '0;

    assign ctrl_m = '{pcsrc: PCSrcM, regwrite: RegWriteM, memtoreg: MemtoRegM};
    assign rd_in  = rd_sel_mem ? dmem.dmem_rdata : '0;

    segment_mem_wb #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_seg (
        .clk      (clk),
        .rst      (rst),
        .load     (seg_load),
        .bubble   (seg_bubble),
        .ctrl_in  (ctrl_m),
        .wa3_in   (WA3M),
        .alu_in   (ALUOutM),
        .rd_in    (rd_in),
        .ctrl_out (ctrl_w),
        .wa3_out  (WA3W),
        .alu_out  (ALUOutW),
        .rd_out   (ReadDataW)
    );

    assign PCSrcW    = ctrl_w.pcsrc;
    assign RegWriteW = ctrl_w.regwrite;
    assign MemtoRegW = ctrl_w.memtoreg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Self-checking bench for mem_stage_ctrl. A driver plays the EX/MEM segment
// (advancing only when StallM is low) and the data memory (ack after a chosen
// latency). Per instruction the expected writeback result and stall count are
// queued; a monitor pops and compares at each retiring falling edge.
// Build with MEM_TIMEOUT_EN to exercise the watchdog (TIMEOUT = 4).
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO    = 4;
    localparam bit          TMO_EN = 1'b1;
`else
    localparam int unsigned TMO    = 15;
    localparam bit          TMO_EN = 1'b0;
`endif
    localparam int unsigned N_INSTR = 300;
    localparam int unsigned BUDGET  = 20000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
    logic [DW-1:0] ALUOutM, WriteDataM;
    logic [AW-1:0] WA3M;
    logic          StallM, PCSrcW, RegWriteW, MemtoRegW, mem_err;
    logic [DW-1:0] ReadDataW, ALUOutW;
    logic [AW-1:0] WA3W;

    mem_stage_ctrl_if #(.DATA_W(DW)) dmem ();

    mem_stage_ctrl #(
        .DATA_W  (DW),
        .REG_AW  (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrcM     (PCSrcM),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .WA3M       (WA3M),
        .dmem       (dmem),
        .StallM     (StallM),
        .PCSrcW     (PCSrcW),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .ReadDataW  (ReadDataW),
        .ALUOutW    (ALUOutW),
        .WA3W       (WA3W),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            pcsrc, rw, m2r, mw;
        logic [AW-1:0] wa3;
        logic [DW-1:0] alu, wdata, rdata;
        int unsigned   lat;
    } instr_t;

    typedef struct {
        bit            pcsrc, rw, m2r, tmo;
        logic [AW-1:0] wa3;
        logic [DW-1:0] alu, rd;
        int unsigned   stalls;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic apply(input instr_t t);
        PCSrcM     = t.pcsrc;
        RegWriteM  = t.rw;
        MemtoRegM  = t.m2r;
        MemWriteM  = t.mw;
        WA3M       = t.wa3;
        ALUOutM    = t.alu;
        WriteDataM = t.wdata;
    endtask

    function automatic instr_t nop_instr();
        instr_t t;
        t.pcsrc = 0; t.rw = 0; t.m2r = 0; t.mw = 0;
        t.wa3 = '0; t.alu = '0; t.wdata = '0; t.rdata = '0; t.lat = 1;
        return t;
    endfunction

    // Directed instructions first, then random ones.
    function automatic instr_t next_instr(input int unsigned idx);
        instr_t      t;
        int unsigned kind;
        kind    = $urandom_range(0, 2);
        t.pcsrc = 1'($urandom_range(0, 1));
        t.rw    = 1'($urandom_range(0, 1));
        t.m2r   = (kind == 1);
        t.mw    = (kind == 2);
        t.wa3   = AW'($urandom);
        t.alu   = $urandom;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.lat   = $urandom_range(1, 5);
        if (TMO_EN && $urandom_range(0, 7) == 0) t.lat = 1000;
        case (idx)
            0: begin t = nop_instr(); t.rw = 1; t.wa3 = 4'd3; t.alu = 32'h0000_00A5; end
            1: begin t = nop_instr(); t.rw = 1; t.m2r = 1; t.wa3 = 4'd5; t.alu = 32'h100;
                     t.lat = 3; t.rdata = 32'hDEAD_BEEF; end
            2: begin t = nop_instr(); t.mw = 1; t.alu = 32'h200; t.wdata = 32'h1234; t.lat = 1; end
            3: begin t = nop_instr(); t.rw = 1; t.m2r = 1; t.wa3 = 4'd7; t.alu = 32'h300;
                     t.lat = 2; t.rdata = 32'h1111_2222; end
            4: begin t = nop_instr(); t.rw = 1; t.m2r = 1; t.wa3 = 4'd8; t.alu = 32'h304;
                     t.lat = 1; t.rdata = 32'h3333_4444; end
            5: if (TMO_EN) begin
                   t = nop_instr(); t.rw = 1; t.m2r = 1; t.wa3 = 4'd9; t.alu = 32'h400; t.lat = 1000;
               end
            default: ;
        endcase
        return t;
    endfunction

    // Reference model: what writeback must show when this instruction retires.
    task automatic push_expected(input instr_t t);
        exp_t e;
        bit   is_mem;
        is_mem   = t.m2r || t.mw;
        e.tmo    = TMO_EN && is_mem && (t.lat > TMO);
        e.pcsrc  = e.tmo ? 1'b0 : t.pcsrc;
        e.rw     = e.tmo ? 1'b0 : t.rw;
        e.m2r    = e.tmo ? 1'b0 : t.m2r;
        e.wa3    = t.wa3;
        e.alu    = t.alu;
        e.rd     = (t.m2r && !e.tmo) ? t.rdata : '0;
        e.stalls = !is_mem ? 0 : (e.tmo ? TMO : t.lat);
        sb.push_back(e);
    endtask

    task automatic driver();
        instr_t      cur;
        int unsigned issued  = 0;
        int unsigned req_cyc = 0;
        bit          stall_s = 1'b0;
        cur = nop_instr();
        while (!done) begin
            @(negedge clk); #1;
            if (!stall_s) begin
                if (issued < N_INSTR) begin
                    cur = next_instr(issued);
                    push_expected(cur);
                    issued++;
                end else begin
                    cur = nop_instr();
                end
                apply(cur);
            end
            // Memory responder: ack in the lat-th request cycle; stray acks
            // while no request is outstanding.
            if (dmem.dmem_req) req_cyc++;
            else               req_cyc = 0;
            if (dmem.dmem_req && req_cyc == cur.lat) begin
                dmem.dmem_ack   = 1'b1;
                dmem.dmem_rdata = cur.rdata;
            end else begin
                dmem.dmem_ack   = dmem.dmem_req ? 1'b0 : ($urandom_range(0, 2) == 0);
                dmem.dmem_rdata = $urandom;
            end
            @(posedge clk);
            stall_s = StallM;
            if (dmem.dmem_req) begin
                chk("req_for_mem_op", cur.m2r | cur.mw, 1);
                chk("dmem_addr",  dmem.dmem_addr,  cur.alu);
                chk("dmem_we",    dmem.dmem_we,    cur.mw);
                chk("dmem_wdata", dmem.dmem_wdata, cur.wdata);
                chk("req_length", (req_cyc <= cur.lat) && (!TMO_EN || req_cyc <= TMO), 1);
            end else begin
                chk("idle_bus", {dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata}, 0);
            end
        end
    endtask

    task automatic monitor();
        exp_t          e;
        bit            st;
        bit            err_exp   = 1'b0;
        int unsigned   stall_cnt = 0;
        int unsigned   popped    = 0;
        int unsigned   cyc       = 0;
        logic [AW-1:0] h_wa3     = '0;
        logic [DW-1:0] h_alu     = '0;
        logic [DW-1:0] h_rd      = '0;
        while (popped < N_INSTR && cyc < BUDGET) begin
            @(posedge clk);
            st = StallM;
            cyc++;
            @(negedge clk); #1;
            if (st) begin
                stall_cnt++;
                chk("bubble_ctrl", {PCSrcW, RegWriteW, MemtoRegW}, 0);
                chk("bubble_data", {WA3W, ALUOutW, ReadDataW}, {h_wa3, h_alu, h_rd});
                chk("mem_err_stall", mem_err, err_exp);
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.tmo) begin
                    e.wa3 = h_wa3; e.alu = h_alu; e.rd = h_rd;
                    err_exp = 1'b1;
                end
                chk("w_ctrl", {PCSrcW, RegWriteW, MemtoRegW}, {e.pcsrc, e.rw, e.m2r});
                chk("w_wa3", WA3W, e.wa3);
                chk("w_alu", ALUOutW, e.alu);
                chk("w_rdata", ReadDataW, e.rd);
                chk("stall_cycles", stall_cnt, e.stalls);
                chk("mem_err", mem_err, err_exp);
                if (!e.tmo) begin
                    h_wa3 = e.wa3; h_alu = e.alu; h_rd = e.rd;
                end
                stall_cnt = 0;
                popped++;
            end
        end
        if (popped < N_INSTR) begin
            errors++;
            $display("FAIL retire_budget: actual %0d retired required %0d", popped, N_INSTR);
        end
        done = 1'b1;
    endtask

    initial begin
        apply(nop_instr());
        dmem.dmem_ack   = 1'b0;
        dmem.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        chk("rst_stall", StallM, 0);
        chk("rst_req", dmem.dmem_req, 0);
        chk("rst_w", {PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW}, 0);
        chk("rst_err", mem_err, 0);
        MemtoRegM = 1'b1; #1;
        chk("rst_stall_memop", StallM, 0);
        chk("rst_req_memop", dmem.dmem_req, 0);

        // Release with an ALU op, then a load that is reset mid-request.
        @(negedge clk); #1;
        rst = 1'b0;
        MemtoRegM = 1'b0; RegWriteM = 1'b1; ALUOutM = 32'hA5; WA3M = 4'd3;
        @(posedge clk);
        chk("alu_nostall", StallM, 0);
        @(negedge clk); #1;
        chk("alu_w", {RegWriteW, WA3W, ALUOutW}, {1'b1, 4'd3, 32'hA5});
        MemtoRegM = 1'b1; ALUOutM = 32'h100; WA3M = 4'd4;
        @(posedge clk);
        chk("ld_stall_idle", StallM, 1);
        @(negedge clk); #1;
        chk("ld_bubble", RegWriteW, 0);
        chk("ld_held", ALUOutW, 32'hA5);
        chk("ld_req", dmem.dmem_req, 1);
        chk("ld_addr", dmem.dmem_addr, 32'h100);
        @(posedge clk);
        chk("ld_stall_req", StallM, 1);
        rst = 1'b1; #1;
        chk("midreq_rst_req", dmem.dmem_req, 0);
        chk("midreq_rst_stall", StallM, 0);
        chk("midreq_rst_w", {PCSrcW, RegWriteW, MemtoRegW, WA3W, ALUOutW, ReadDataW}, 0);
        @(negedge clk); #1;
        apply(nop_instr());
        rst = 1'b0;
        @(posedge clk);
        chk("post_rst_req", dmem.dmem_req, 0);
        chk("post_rst_stall", StallM, 0);

        fork
            driver();
            monitor();
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
